dram_arbiter: RTL

- Shares the single DRAM master FIFO channel between N_REQ requesters, e.g. CPU instruction fetch and data access, in place of the standalone DRAM test master.
- Sits between the requesters and the master side of the DRAM buffer.
- Round-robin arbitration with a one-entry registered issue slot.
- Tracks outstanding reads in an in-order tag FIFO so read responses return to the requester that issued them.

---
 rtl/dram_arb_pkg.sv | 24 ++
 rtl/tag_fifo.sv | 62 ++++++
 rtl/dram_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and default sizing for the DRAM requester arbiter.
//   N_REQ_DEF / ADDR_W_DEF / DATA_W_DEF / MAX_OUT_DEF : default parameter values
//   TAG_W      : requester-index width for the default requester count
//   dram_req_t : request payload {we, addr, wdata} at default widths
//   tag_width(): requester-index width for any requester count (min 1 bit)
package dram_arb_pkg;

    localparam int unsigned N_REQ_DEF   = 2;
    localparam int unsigned ADDR_W_DEF  = 27;
    localparam int unsigned DATA_W_DEF  = 128;
    localparam int unsigned MAX_OUT_DEF = 4;
    localparam int unsigned TAG_W       = $clog2(N_REQ_DEF);

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } dram_req_t;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester tags for reads in flight.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write din_i (accepted when not full, or when popping this cycle)
//   pop_i      : drop the head entry (ignored when empty)
//   head_o     : oldest tag
//   empty_o    : no tags stored
//   full_o     : DEPTH tags stored
// DEPTH must be a power of two so the pointers wrap naturally.
module tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a full FIFO may take a push then.
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer, count and storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM master request channel between N_REQ requesters.
//   clk, rst           : clock, synchronous active-high reset
//   s_req_*            : per-requester request (valid/ready/we/addr/wdata, packed per requester)
//   s_resp_valid/rdata : read response routed back to the issuing requester
//   m_req_*            : registered one-entry issue slot towards the DRAM buffer
//   m_resp_*           : in-order read data from the DRAM buffer, no backpressure
//   err                : sticky flag, set by a response with no read outstanding
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         s_req_valid,
    output logic [N_REQ-1:0]         s_req_ready,
    input  logic [N_REQ-1:0]         s_req_we,
    input  logic [N_REQ*ADDR_W-1:0]  s_req_addr,
    input  logic [N_REQ*DATA_W-1:0]  s_req_wdata,
    output logic [N_REQ-1:0]         s_resp_valid,
    output logic [DATA_W-1:0]        s_resp_rdata,
    output logic                     m_req_valid,
    input  logic                     m_req_ready,
    output logic                     m_req_we,
    output logic [ADDR_W-1:0]        m_req_addr,
    output logic [DATA_W-1:0]        m_req_wdata,
    input  logic                     m_resp_valid,
    input  logic [DATA_W-1:0]        m_resp_rdata,
    output logic                     err
);

    localparam int unsigned TW = tag_width(N_REQ);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

    slot_t            slot_q, slot_d;
    logic             valid_q, valid_d;
    logic [TW-1:0]    ptr_q, ptr_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] elig;
    logic [TW-1:0]    rr_idx;
    logic [TW-1:0]    winner;
    logic             any_elig;
    logic             slot_free;
    logic             grant;
    logic             rd_push;
    logic             rsp_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [TW-1:0]    fifo_head;

    assign slot_free = !valid_q || m_req_ready;
    assign rsp_pop   = m_resp_valid && !fifo_empty;

    // Reads need a free tag entry, or one freed by this cycle's response
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig[i] = s_req_valid[i] && (s_req_we[i] || !fifo_full || rsp_pop);
        end
    end

    // Round-robin search starting at the pointer
    always_comb begin
        rr_idx   = '0;
        winner   = '0;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rr_idx = TW'((32'(ptr_q) + k) % N_REQ);
            if (!any_elig && elig[rr_idx]) begin
                any_elig = 1'b1;
                winner   = rr_idx;
            end
        end
    end

    assign grant        = slot_free && any_elig && !rst;
    assign rd_push      = grant && !s_req_we[winner];
    assign s_req_ready  = grant ? (N_REQ'(1) << winner) : '0;
    assign s_resp_valid = (rsp_pop && !rst) ? (N_REQ'(1) << fifo_head) : '0;
    assign s_resp_rdata = m_resp_rdata;

    assign m_req_valid = valid_q;
    assign m_req_we    = slot_q.we;
    assign m_req_addr  = slot_q.addr;
    assign m_req_wdata = slot_q.wdata;
    assign err         = err_q;

    // Next-state: issue slot, pointer, sticky error
    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        err_d   = err_q || (m_resp_valid && fifo_empty);
        if (slot_free) begin
            valid_d = grant;
        end
        if (grant) begin
            slot_d.we    = s_req_we[winner];
            slot_d.addr  = s_req_addr[32'(winner)*ADDR_W +: ADDR_W];
            slot_d.wdata = s_req_wdata[32'(winner)*DATA_W +: DATA_W];
            ptr_d        = TW'((32'(winner) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (TW)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_push),
        .pop_i   (rsp_pop),
        .din_i   (winner),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
